// File: rtl/cdc_bus_tx.sv
// Source side of a toggle (2-phase) req/ack multi-bit CDC crossing: holds each word on dd_out
// and flips req_out, then waits for the re-synchronised ack toggle. Optional watchdog: CDC_BUS_TX_TIMEOUT_EN.
module cdc_bus_tx #(
  parameter int DATA_WIDTH     = 32,
  parameter int SYNC_FF        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_s,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] dd_out,
  output logic                  req_out,
  input  logic                  ack_in,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_ready;
  logic                  w_ready_nxt;
  logic [DATA_WIDTH-1:0] r_dd;
  logic [DATA_WIDTH-1:0] w_dd_nxt;
  logic                  r_req;
  logic                  w_req_nxt;
  logic                  r_busy;
  logic                  w_busy_nxt;
  logic                  r_done;
  logic                  w_done_nxt;
  logic [SYNC_FF-1:0]    r_sync;
  logic                  w_ack_s;
  logic                  w_accept;
  logic                  w_match;

  assign w_ack_s  = r_sync[SYNC_FF-1];
  assign w_accept = (r_state == ST_IDLE) && s_valid && r_ready;
  // The returning ack equals our req once the receiver has latched the current word.
  assign w_match  = (r_state == ST_WAIT) && (w_ack_s == r_req);

  // ack_in synchroniser: the only consumer of the asynchronous ack_in.
  always_ff @(posedge clk_s) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_FF-2:0], ack_in};
    end
  end

  // State and registered-output update.
  always_ff @(posedge clk_s) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_dd    <= '0;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= w_ready_nxt;
      r_dd    <= w_dd_nxt;
      r_req   <= w_req_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state and next-output decode; ack toggles seen while idle are ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_ready_nxt = r_ready;
    w_dd_nxt    = r_dd;
    w_req_nxt   = r_req;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_dd_nxt    = s_data;
          w_req_nxt   = ~r_req;
          w_ready_nxt = 1'b0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = ST_WAIT;
        end else begin
          w_ready_nxt = 1'b1;
        end
      end
      ST_WAIT: begin
        if (w_match) begin
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_ready_nxt = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_ready_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign s_ready = r_ready;
  assign dd_out  = r_dd;
  assign req_out = r_req;
  assign busy    = r_busy;
  assign done    = r_done;

`ifdef CDC_BUS_TX_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_terr;

  // Watchdog: counts WAIT cycles, saturates, and flags a sticky error without aborting.
  always_ff @(posedge clk_s) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_terr <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if ((r_state == ST_WAIT) && !w_match) begin
      if (r_cnt == CNT_MAX) begin
        r_terr <= 1'b1;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign timeout_err = r_terr;
`else
  assign timeout_err = (TIMEOUT_CYCLES < 0) ? 1'b1 : 1'b0;
`endif

endmodule

// File: tb/tb_cdc_bus_tx.sv
// Randomised and directed bench for cdc_bus_tx with a cycle-level behavioural model and a
// toggle receiver model; the watchdog checks are compiled in with CDC_BUS_TX_TIMEOUT_EN.
module tb_cdc_bus_tx;
  localparam int DW   = 32;
  localparam int SFF  = 4;
  localparam int TOUT = 16;

  logic          clk_s = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] dd_out;
  logic          req_out;
  logic          ack_in = 1'b0;
  logic          busy;
  logic          done;
  logic          timeout_err;

  cdc_bus_tx #(.DATA_WIDTH(DW), .SYNC_FF(SFF), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk_s(clk_s), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .dd_out(dd_out), .req_out(req_out), .ack_in(ack_in), .busy(busy), .done(done),
    .timeout_err(timeout_err)
  );

  always #5 clk_s = ~clk_s;

  int errors = 0;
  int checks = 0;

  // model state
  logic          m_ready, m_req, m_busy, m_done, m_terr;
  logic [DW-1:0] m_dd;
  int            m_wait;
  bit            m_acc;
  logic          ack_q[$];

  // receiver model
  bit rx_en = 1'b0;
  int rx_delay = 2;
  int rx_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour: ack seen SFF edges late; accept in idle, complete on matching ack.
  task automatic model_step();
    logic acks;
    m_acc = 1'b0;
    if (!rst_n) begin
      m_ready = 1'b0; m_req = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_terr = 1'b0;
      m_dd = '0; m_wait = 0;
      ack_q = {};
      repeat (SFF) ack_q.push_back(1'b0);
    end else begin
      acks = ack_q[SFF-1];
      ack_q.push_front(ack_in);
      void'(ack_q.pop_back());
      m_done = 1'b0;
      if (!m_busy) begin
        if (s_valid && m_ready) begin
          m_dd = s_data; m_req = ~m_req; m_ready = 1'b0; m_busy = 1'b1; m_wait = 0; m_acc = 1'b1;
        end else begin
          m_ready = 1'b1;
        end
      end else if (acks == m_req) begin
        m_done = 1'b1; m_busy = 1'b0; m_ready = 1'b1;
      end else begin
        m_wait++;
`ifdef CDC_BUS_TX_TIMEOUT_EN
        if (m_wait >= TOUT) m_terr = 1'b1;
`endif
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_s);
    model_step();
    @(negedge clk_s);
    chk("s_ready", {63'd0, s_ready}, {63'd0, m_ready});
    chk("dd_out", {32'd0, dd_out}, {32'd0, m_dd});
    chk("req_out", {63'd0, req_out}, {63'd0, m_req});
    chk("busy", {63'd0, busy}, {63'd0, m_busy});
    chk("done", {63'd0, done}, {63'd0, m_done});
    chk("timeout_err", {63'd0, timeout_err}, {63'd0, m_terr});
    if (rx_en) begin
      if (req_out !== ack_in) begin
        rx_cnt++;
        if (rx_cnt >= rx_delay) begin
          ack_in = req_out;
          rx_cnt = 0;
        end
      end else begin
        rx_cnt = 0;
      end
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; ack_in = 1'b0; rx_en = 1'b0; rx_cnt = 0; s_valid = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_done(input int lim, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: got no done, required done within %0d cycles", nm, lim);
    end
  endtask

  initial begin
    logic [DW-1:0] words[4];
    int k, ndone, cyc;
    words[0] = 32'd1; words[1] = 32'd2; words[2] = 32'd3; words[3] = 32'd4;

    // reset release
    rst_n = 1'b0;
    repeat (5) begin
      tick();
      chk("rst_ready", {63'd0, s_ready}, 64'd0);
      chk("rst_dd", {32'd0, dd_out}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
    end
    rst_n = 1'b1;
    tick();
    chk("rel_ready", {63'd0, s_ready}, 64'd1);
    chk("rel_req", {63'd0, req_out}, 64'd0);

    // single transfer
    s_data = 32'hA5A5_0001; s_valid = 1'b1;
    tick();
    s_valid = 1'b0; s_data = 32'h0;
    chk("single_dd", {32'd0, dd_out}, 64'h0000_0000_A5A5_0001);
    chk("single_req", {63'd0, req_out}, 64'd1);
    chk("single_ready", {63'd0, s_ready}, 64'd0);
    repeat (2) tick();
    ack_in = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("single_done_lat", {63'd0, done}, (i == 5) ? 64'd1 : 64'd0);
    end
    chk("single_ready_done", {63'd0, s_ready}, 64'd1);
    chk("single_dd_hold", {32'd0, dd_out}, 64'h0000_0000_A5A5_0001);

    // back-to-back
    do_reset(2);
    rx_en = 1'b1; rx_delay = 2;
    k = 0; ndone = 0; cyc = 0;
    s_valid = 1'b1; s_data = words[0];
    while (ndone < 4 && cyc < 200) begin
      tick();
      cyc++;
      if (done === 1'b1) ndone++;
      if (m_acc) begin
        chk("b2b_dd", {32'd0, dd_out}, {32'd0, words[k]});
        k++;
        if (k == 4) s_valid = 1'b0;
        else s_data = words[k];
      end
    end
    chk("b2b_accepts", 64'(k), 64'd4);
    chk("b2b_dones", 64'(ndone), 64'd4);
    chk("b2b_req_end", {63'd0, req_out}, 64'd0);

    // stall with ack withheld
    do_reset(2);
    s_valid = 1'b1; s_data = 32'h1234_5678;
    tick();
    for (int i = 0; i < 50; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data = $urandom;
      tick();
      chk("stall_busy", {63'd0, busy}, 64'd1);
      chk("stall_done", {63'd0, done}, 64'd0);
      chk("stall_dd", {32'd0, dd_out}, 64'h0000_0000_1234_5678);
      chk("stall_req", {63'd0, req_out}, 64'd1);
    end
    s_valid = 1'b0;
    ack_in = 1'b1;
    wait_done(20, "stall_release");

    // reset mid-transfer
    do_reset(2);
    s_valid = 1'b1; s_data = 32'h77;
    tick();
    s_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0; ack_in = 1'b0;
    tick();
    chk("mid_req", {63'd0, req_out}, 64'd0);
    chk("mid_busy", {63'd0, busy}, 64'd0);
    chk("mid_dd", {32'd0, dd_out}, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("mid_ready", {63'd0, s_ready}, 64'd1);
    rx_en = 1'b1; rx_delay = 2;
    s_valid = 1'b1; s_data = 32'h99;
    tick();
    s_valid = 1'b0;
    wait_done(30, "mid_recover");
    chk("mid_recover_dd", {32'd0, dd_out}, 64'h99);

    // randomised traffic with random receiver latency and occasional resets
    do_reset(2);
    rx_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data = $urandom;
      if (rx_cnt == 0) rx_delay = $urandom_range(1, 6);
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0; ack_in = 1'b0; rx_cnt = 0;
      end else begin
        rst_n = 1'b1;
      end
      tick();
    end
    rst_n = 1'b1;

`ifdef CDC_BUS_TX_TIMEOUT_EN
    do_reset(2);
    s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
    tick();
    s_valid = 1'b0;
    repeat (15) tick();
    chk("tout_before", {63'd0, timeout_err}, 64'd0);
    tick();
    chk("tout_set", {63'd0, timeout_err}, 64'd1);
    repeat (20) tick();
    chk("tout_sticky", {63'd0, timeout_err}, 64'd1);
    ack_in = 1'b1;
    wait_done(20, "tout_complete");
    tick();
    chk("tout_after_done", {63'd0, timeout_err}, 64'd1);
`else
    chk("tout_tied", {63'd0, timeout_err}, 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
